exec_sequencer: RTL

//  Multi-cycle fetch/execute sequencer and the consumer side of control_unit. It owns PC, A and D.
//  It fetches an instruction, reads *A, and drives instr/dat_a/dat_d/dat_dref_a to control_unit.
//  It then consumes dat_r/a/d/dref_a/j: writes *A, updates A/D and advances or jumps PC.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/exec_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CI_BIT = 15;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        STORE = 2'd3
    } state_t;

endpackage

// File: rtl/exec_sequencer.sv
// Fetch/load/execute/store sequencer owning PC, A and D; consumes control_unit results.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [WORD_W-1:0] dmem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] dat_a,
    output logic [WORD_W-1:0] dat_d,
    output logic [WORD_W-1:0] dat_dref_a,
    input  logic [WORD_W-1:0] dat_r,
    input  logic              a,
    input  logic              d,
    input  logic              dref_a,
    input  logic              j,
    output logic [WORD_W-1:0] pc,
    output logic [CNT_W-1:0]  retired
);

    state_t              r_state;
    state_t              w_next;
    logic                r_imem_req;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic [WORD_W-1:0]   r_pc;
    logic [WORD_W-1:0]   r_a;
    logic [WORD_W-1:0]   r_d;
    logic [WORD_W-1:0]   r_instr;
    logic [WORD_W-1:0]   r_dref;
    logic [WORD_W-1:0]   r_wbuf;
    logic                r_ca;
    logic                r_cd;
    logic                r_cj;
    logic [CNT_W-1:0]    r_ret;

    logic                w_commit;
    logic                w_latch;
    logic [WORD_W-1:0]   w_cr;
    logic                w_ca;
    logic                w_cd;
    logic                w_cj;

    // Next state plus commit selection: live control_unit flags in EXEC, latched copies in STORE.
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        w_latch  = 1'b0;
        w_cr     = dat_r;
        w_ca     = a;
        w_cd     = d;
        w_cj     = j;
        case (r_state)
            FETCH: begin
                if (r_imem_req && imem_ack) begin
                    w_next = imem_rdata[CI_BIT] ? LOAD : EXEC;
                end
            end
            LOAD: begin
                if (r_dmem_req && dmem_ack) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                if (dref_a) begin
                    w_latch = 1'b1;
                    w_next  = STORE;
                end else begin
                    w_commit = 1'b1;
                    w_next   = FETCH;
                end
            end
            STORE: begin
                w_cr = r_wbuf;
                w_ca = r_ca;
                w_cd = r_cd;
                w_cj = r_cj;
                if (r_dmem_req && dmem_ack) begin
                    w_commit = 1'b1;
                    w_next   = FETCH;
                end
            end
            default: w_next = FETCH;
        endcase
    end

    // Requests are registered from the next state so a zero-wait ack chains without bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pc       <= RESET_PC;
            r_a        <= '0;
            r_d        <= '0;
            r_instr    <= '0;
            r_dref     <= '0;
            r_wbuf     <= '0;
            r_ca       <= 1'b0;
            r_cd       <= 1'b0;
            r_cj       <= 1'b0;
            r_ret      <= '0;
        end else begin
            r_state    <= w_next;
            r_imem_req <= (w_next == FETCH);
            r_dmem_req <= (w_next == LOAD) || (w_next == STORE);
            r_dmem_we  <= (w_next == STORE);
            if ((r_state == FETCH) && r_imem_req && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if ((r_state == LOAD) && r_dmem_req && dmem_ack) begin
                r_dref <= dmem_rdata;
            end
            if (w_latch) begin
                r_wbuf <= dat_r;
                r_ca   <= a;
                r_cd   <= d;
                r_cj   <= j;
            end
            // Jump target is the pre-commit A even when A is also written.
            if (w_commit) begin
                if (w_ca) begin
                    r_a <= w_cr;
                end
                if (w_cd) begin
                    r_d <= w_cr;
                end
                r_pc  <= w_cj ? r_a : (r_pc + WORD_W'(1));
                r_ret <= r_ret + CNT_W'(1);
            end
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_a;
    assign dmem_wdata = r_wbuf;
    assign instr      = r_instr;
    assign dat_a      = r_a;
    assign dat_d      = r_d;
    assign dat_dref_a = r_dref;
    assign pc         = r_pc;
    assign retired    = r_ret;

endmodule
